// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, memory-stage and external-memory signals that pass
// through mem_port_arbiter. The master modport is the arbiter's view; the
// slave modport is the view of the core stages and memory around it.
interface mem_port_arbiter_if;
    // fetch stage
    logic        InstrReqF;
    logic [31:0] PCF;
    logic [31:0] InstrF;
    logic        InstrValidF;
    logic        StallF;
    // memory stage
    logic        DataReqM;
    logic        DataWeM;
    logic [31:0] DataAddrM;
    logic [31:0] WriteDataM;
    logic [3:0]  ByteEnM;
    logic [31:0] ReadDataM;
    logic        DataValidM;
    logic        StallM;
    // external memory
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        input  InstrReqF, PCF, DataReqM, DataWeM, DataAddrM, WriteDataM, ByteEnM,
        input  mem_ready, mem_rdata,
        output InstrF, InstrValidF, StallF, ReadDataM, DataValidM, StallM,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        output InstrReqF, PCF, DataReqM, DataWeM, DataAddrM, WriteDataM, ByteEnM,
        output mem_ready, mem_rdata,
        input  InstrF, InstrValidF, StallF, ReadDataM, DataValidM, StallM,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// instruction fetch (read-only) and the memory stage (load/store).
// One requester is granted at a time; the mem_* request is held until
// mem_ready, and read data comes back through registered one-cycle valids.
// Optional build macro MEMARB_RR_EN: round-robin on contended grants instead
// of fixed data-first priority.
module mem_port_arbiter (
    input  logic clk,
    input  logic reset,
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t      state_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic [3:0]  mem_wmask_reg;
    logic [31:0] instr_reg;
    logic        instr_valid_reg;
    logic [31:0] read_data_reg;
    logic        data_valid_reg;
`ifdef MEMARB_RR_EN
    logic        rr_ptr_reg;   // 1 = data won the last contended grant
`endif

    logic pend_i;
    logic pend_d;
    logic cand_i;
    logic cand_d;
    logic pick_i;
    logic pick_d;
    logic advance;

    // A requester whose valid pulse is showing is still presenting the request
    // that just completed; it must not be granted a second time.
    assign pend_i = bus.InstrReqF & ~instr_valid_reg;
    assign pend_d = bus.DataReqM  & ~data_valid_reg;

    // Candidates for the next grant: both in IDLE, only the other side when a
    // transaction completes this cycle, none while still waiting on memory.
    always_comb begin
        cand_i  = 1'b0;
        cand_d  = 1'b0;
        advance = 1'b0;
        case (state_reg)
            IDLE: begin
                advance = 1'b1;
                cand_i  = pend_i;
                cand_d  = pend_d;
            end
            BUSY_I: begin
                advance = bus.mem_ready;
                cand_d  = bus.mem_ready & pend_d;
            end
            BUSY_D: begin
                advance = bus.mem_ready;
                cand_i  = bus.mem_ready & pend_i;
            end
            default: begin
                advance = 1'b1;
            end
        endcase
    end

    // Grant selection among the candidates.
    always_comb begin
`ifdef MEMARB_RR_EN
        pick_d = cand_d & (~cand_i | ~rr_ptr_reg);
`else
        pick_d = cand_d;
`endif
        pick_i = cand_i & ~pick_d;
    end

    // Arbiter FSM with registered memory request and read-data/valid outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            mem_req_reg     <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= 32'h0;
            mem_wdata_reg   <= 32'h0;
            mem_wmask_reg   <= 4'b0000;
            instr_reg       <= 32'h0;
            instr_valid_reg <= 1'b0;
            read_data_reg   <= 32'h0;
            data_valid_reg  <= 1'b0;
`ifdef MEMARB_RR_EN
            rr_ptr_reg      <= 1'b0;
`endif
        end else begin
            instr_valid_reg <= 1'b0;
            data_valid_reg  <= 1'b0;

            case (state_reg)
                BUSY_I: begin
                    if (bus.mem_ready) begin
                        // A flushed fetch still lands in InstrF but raises no valid.
                        instr_reg       <= bus.mem_rdata;
                        instr_valid_reg <= bus.InstrReqF;
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ready) begin
                        if (!mem_we_reg) begin
                            read_data_reg <= bus.mem_rdata;
                        end
                        data_valid_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase

            if (advance) begin
                if (pick_d) begin
                    state_reg     <= BUSY_D;
                    mem_req_reg   <= 1'b1;
                    mem_we_reg    <= bus.DataWeM;
                    mem_addr_reg  <= bus.DataAddrM;
                    mem_wdata_reg <= bus.DataWeM ? bus.WriteDataM : 32'h0;
                    mem_wmask_reg <= bus.DataWeM ? bus.ByteEnM : 4'b0000;
                end else if (pick_i) begin
                    state_reg     <= BUSY_I;
                    mem_req_reg   <= 1'b1;
                    mem_we_reg    <= 1'b0;
                    mem_addr_reg  <= bus.PCF;
                    mem_wdata_reg <= 32'h0;
                    mem_wmask_reg <= 4'b0000;
                end else begin
                    state_reg     <= IDLE;
                    mem_req_reg   <= 1'b0;
                    mem_we_reg    <= 1'b0;
                    mem_wmask_reg <= 4'b0000;
                end
`ifdef MEMARB_RR_EN
                // Only contended grants move the pointer.
                if (cand_i && cand_d) begin
                    rr_ptr_reg <= pick_d;
                end
`endif
            end
        end
    end

    assign bus.mem_req     = mem_req_reg;
    assign bus.mem_we      = mem_we_reg;
    assign bus.mem_addr    = mem_addr_reg;
    assign bus.mem_wdata   = mem_wdata_reg;
    assign bus.mem_wmask   = mem_wmask_reg;
    assign bus.InstrF      = instr_reg;
    assign bus.InstrValidF = instr_valid_reg;
    assign bus.ReadDataM   = read_data_reg;
    assign bus.DataValidM  = data_valid_reg;
    assign bus.StallF      = bus.InstrReqF & ~instr_valid_reg;
    assign bus.StallM      = bus.DataReqM  & ~data_valid_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for a cycle are driven 1 time unit after the rising edge and
    // outputs are checked 1 unit later, well away from both edges.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.InstrReqF  = 1'b0;
        bus.PCF        = 32'h0;
        bus.DataReqM   = 1'b0;
        bus.DataWeM    = 1'b0;
        bus.DataAddrM  = 32'h0;
        bus.WriteDataM = 32'h0;
        bus.ByteEnM    = 4'b0000;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = 32'h0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b expected 0", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %0b expected 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); end
        checks++; if (bus.mem_wmask !== 4'b0000) begin errors++; $display("FAIL reset_mem_wmask: got %b expected 0000", bus.mem_wmask); end
        checks++; if (bus.InstrF !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", bus.InstrF); end
        checks++; if (bus.ReadDataM !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.ReadDataM); end
        checks++; if ({bus.InstrValidF, bus.DataValidM} !== 2'b00) begin errors++; $display("FAIL reset_valids: got %b expected 00", {bus.InstrValidF, bus.DataValidM}); end
        checks++; if ({bus.StallF, bus.StallM} !== 2'b00) begin errors++; $display("FAIL reset_stalls: got %b expected 00", {bus.StallF, bus.StallM}); end
        $display("test_reset done");
    endtask

    task automatic test_single_fetch();
        // cycle 0: request seen in IDLE
        tick();
        bus.InstrReqF = 1'b1;
        bus.PCF       = 32'h0000_0010;
        #1;
        checks++; if (bus.StallF !== 1'b1) begin errors++; $display("FAIL fetch_c0_stall: got %0b expected 1", bus.StallF); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL fetch_c0_req: got %0b expected 0", bus.mem_req); end
        // cycle 1: BUSY_I, zero-wait memory
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_0093;
        #1;
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL fetch_c1_req: got %0b expected 1", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h10) begin errors++; $display("FAIL fetch_c1_addr: got %h expected 00000010", bus.mem_addr); end
        checks++; if ({bus.mem_we, bus.mem_wmask} !== 5'b0) begin errors++; $display("FAIL fetch_c1_we_mask: got %b expected 00000", {bus.mem_we, bus.mem_wmask}); end
        checks++; if (bus.StallF !== 1'b1) begin errors++; $display("FAIL fetch_c1_stall: got %0b expected 1", bus.StallF); end
        // cycle 2: valid pulse
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        #1;
        checks++; if (bus.InstrValidF !== 1'b1) begin errors++; $display("FAIL fetch_c2_valid: got %0b expected 1", bus.InstrValidF); end
        checks++; if (bus.InstrF !== 32'h93) begin errors++; $display("FAIL fetch_c2_instr: got %h expected 00000093", bus.InstrF); end
        checks++; if (bus.StallF !== 1'b0) begin errors++; $display("FAIL fetch_c2_stall: got %0b expected 0", bus.StallF); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL fetch_c2_req: got %0b expected 0", bus.mem_req); end
        // cycle 3: request withdrawn, pulse gone
        tick();
        bus.InstrReqF = 1'b0;
        #1;
        checks++; if (bus.InstrValidF !== 1'b0) begin errors++; $display("FAIL fetch_c3_valid: got %0b expected 0", bus.InstrValidF); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL fetch_c3_req: got %0b expected 0", bus.mem_req); end
        $display("test_single_fetch done");
    endtask

    task automatic test_store_wait();
        tick();
        bus.DataReqM   = 1'b1;
        bus.DataWeM    = 1'b1;
        bus.DataAddrM  = 32'h100;
        bus.WriteDataM = 32'hDEAD_BEEF;
        bus.ByteEnM    = 4'b0011;
        #1;
        checks++; if (bus.StallM !== 1'b1) begin errors++; $display("FAIL store_c0_stall: got %0b expected 1", bus.StallM); end
        // cycles 1..4: three wait states then ready
        for (int c = 1; c <= 4; c++) begin
            tick();
            bus.mem_ready = (c == 4);
            bus.mem_rdata = 32'hBAD0_BAD0;
            #1;
            checks++; if ({bus.mem_req, bus.mem_we} !== 2'b11) begin errors++; $display("FAIL store_c%0d_req_we: got %b expected 11", c, {bus.mem_req, bus.mem_we}); end
            checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL store_c%0d_addr: got %h expected 00000100", c, bus.mem_addr); end
            checks++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_c%0d_wdata: got %h expected deadbeef", c, bus.mem_wdata); end
            checks++; if (bus.mem_wmask !== 4'b0011) begin errors++; $display("FAIL store_c%0d_wmask: got %b expected 0011", c, bus.mem_wmask); end
            checks++; if ({bus.DataValidM, bus.StallM} !== 2'b01) begin errors++; $display("FAIL store_c%0d_valid_stall: got %b expected 01", c, {bus.DataValidM, bus.StallM}); end
        end
        // cycle 5: completion pulse, no read data written
        tick();
        bus.mem_ready = 1'b0;
        #1;
        checks++; if (bus.DataValidM !== 1'b1) begin errors++; $display("FAIL store_c5_valid: got %0b expected 1", bus.DataValidM); end
        checks++; if (bus.ReadDataM !== 32'h0) begin errors++; $display("FAIL store_c5_rdata: got %h expected 00000000", bus.ReadDataM); end
        checks++; if (bus.StallM !== 1'b0) begin errors++; $display("FAIL store_c5_stall: got %0b expected 0", bus.StallM); end
        tick();
        clear_inputs();
        #1;
        checks++; if ({bus.DataValidM, bus.mem_req} !== 2'b00) begin errors++; $display("FAIL store_c6_valid_req: got %b expected 00", {bus.DataValidM, bus.mem_req}); end
        $display("test_store_wait done");
    endtask

    task automatic test_simultaneous();
        // cycle 0: both request a read
        tick();
        bus.InstrReqF = 1'b1;
        bus.PCF       = 32'h20;
        bus.DataReqM  = 1'b1;
        bus.DataWeM   = 1'b0;
        bus.DataAddrM = 32'h200;
        bus.mem_ready = 1'b1;
        #1;
        // cycle 1: data granted first
        tick();
        bus.mem_rdata = 32'h0000_1111;
        #1;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin errors++; $display("FAIL sim_c1_grant: got req=%0b addr=%h expected req=1 addr=00000200", bus.mem_req, bus.mem_addr); end
        checks++; if (bus.mem_wmask !== 4'b0000) begin errors++; $display("FAIL sim_c1_wmask: got %b expected 0000", bus.mem_wmask); end
        // cycle 2: fetch granted with no idle gap
        tick();
        bus.mem_rdata = 32'h0000_2222;
        #1;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h20) begin errors++; $display("FAIL sim_c2_grant: got req=%0b addr=%h expected req=1 addr=00000020", bus.mem_req, bus.mem_addr); end
        checks++; if (bus.DataValidM !== 1'b1 || bus.ReadDataM !== 32'h1111) begin errors++; $display("FAIL sim_c2_load: got valid=%0b data=%h expected valid=1 data=00001111", bus.DataValidM, bus.ReadDataM); end
        checks++; if ({bus.StallF, bus.StallM} !== 2'b10) begin errors++; $display("FAIL sim_c2_stalls: got %b expected 10", {bus.StallF, bus.StallM}); end
        // cycle 3: fetch data valid, fourth cycle overall
        tick();
        bus.DataReqM  = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        checks++; if (bus.InstrValidF !== 1'b1 || bus.InstrF !== 32'h2222) begin errors++; $display("FAIL sim_c3_fetch: got valid=%0b instr=%h expected valid=1 instr=00002222", bus.InstrValidF, bus.InstrF); end
        checks++; if (bus.DataValidM !== 1'b0) begin errors++; $display("FAIL sim_c3_dvalid: got %0b expected 0", bus.DataValidM); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL sim_c3_req: got %0b expected 0", bus.mem_req); end
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL sim_c4_req: got %0b expected 0", bus.mem_req); end
        $display("test_simultaneous done");
    endtask

    // Both requesters keep requesting; every memory cycle is zero-wait, so each
    // BUSY cycle is one grant, identified by address region.
    task automatic test_alternation();
        byte exp_seq [4];
        byte got_seq [4];
        int  n;
        exp_seq[0] = "D"; exp_seq[1] = "I"; exp_seq[2] = "D"; exp_seq[3] = "I";
        n = 0;
        apply_reset();
        tick();
        bus.InstrReqF = 1'b1;
        bus.PCF       = 32'h300;
        bus.DataReqM  = 1'b1;
        bus.DataWeM   = 1'b0;
        bus.DataAddrM = 32'h400;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0A0A_0A0A;
        for (int c = 0; c < 20 && n < 4; c++) begin
            tick();
            if (bus.mem_req === 1'b1) begin
                got_seq[n] = (bus.mem_addr == 32'h400) ? "D" : "I";
                n++;
            end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL alt_timeout: got %0d grants expected 4", n); end
        for (int k = 0; k < n; k++) begin
            checks++; if (got_seq[k] !== exp_seq[k]) begin errors++; $display("FAIL alt_grant%0d: got %s expected %s", k, got_seq[k], exp_seq[k]); end
        end
        tick();
        clear_inputs();
        repeat (2) tick();
        $display("test_alternation done");
    endtask

    // Second contended grant after the alternation run: round-robin hands it
    // to fetch, fixed priority to data. The loser follows back-to-back.
    task automatic test_contention_priority();
        logic [31:0] first_addr;
        logic [31:0] second_addr;
`ifdef MEMARB_RR_EN
        first_addr  = 32'h500;
        second_addr = 32'h700;
`else
        first_addr  = 32'h700;
        second_addr = 32'h500;
`endif
        tick();
        bus.InstrReqF = 1'b1;
        bus.PCF       = 32'h500;
        bus.DataReqM  = 1'b1;
        bus.DataWeM   = 1'b0;
        bus.DataAddrM = 32'h700;
        #1;
        tick();
        bus.mem_ready = 1'b1;
        #1;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== first_addr) begin errors++; $display("FAIL cont_first: got req=%0b addr=%h expected req=1 addr=%h", bus.mem_req, bus.mem_addr, first_addr); end
        tick();
        #1;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== second_addr) begin errors++; $display("FAIL cont_second: got req=%0b addr=%h expected req=1 addr=%h", bus.mem_req, bus.mem_addr, second_addr); end
        tick();
        clear_inputs();
        repeat (2) tick();
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL cont_idle: got %0b expected 0", bus.mem_req); end
        $display("test_contention_priority done");
    endtask

    task automatic test_flush();
        tick();
        bus.InstrReqF = 1'b1;
        bus.PCF       = 32'h50;
        #1;
        tick();
        #1;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h50) begin errors++; $display("FAIL flush_c1_grant: got req=%0b addr=%h expected req=1 addr=00000050", bus.mem_req, bus.mem_addr); end
        tick();
        bus.InstrReqF = 1'b0;
        #1;
        checks++; if (bus.StallF !== 1'b0) begin errors++; $display("FAIL flush_c2_stall: got %0b expected 0", bus.StallF); end
        tick();
        #1;
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL flush_c3_req: got %0b expected 1", bus.mem_req); end
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_5555;
        #1;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h50) begin errors++; $display("FAIL flush_c4_held: got req=%0b addr=%h expected req=1 addr=00000050", bus.mem_req, bus.mem_addr); end
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        #1;
        checks++; if (bus.InstrValidF !== 1'b0) begin errors++; $display("FAIL flush_c5_valid: got %0b expected 0", bus.InstrValidF); end
        checks++; if (bus.InstrF !== 32'h5555) begin errors++; $display("FAIL flush_c5_instr: got %h expected 00005555", bus.InstrF); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL flush_c5_req: got %0b expected 0", bus.mem_req); end
        tick();
        #1;
        checks++; if ({bus.InstrValidF, bus.mem_req} !== 2'b00) begin errors++; $display("FAIL flush_c6_idle: got %b expected 00", {bus.InstrValidF, bus.mem_req}); end
        $display("test_flush done");
    endtask

    task automatic test_reset_mid();
        tick();
        bus.DataReqM   = 1'b1;
        bus.DataWeM    = 1'b1;
        bus.DataAddrM  = 32'h600;
        bus.WriteDataM = 32'h1234_5678;
        bus.ByteEnM    = 4'b1111;
        #1;
        tick();
        #1;
        checks++; if ({bus.mem_req, bus.mem_we} !== 2'b11) begin errors++; $display("FAIL rmid_busy: got %b expected 11", {bus.mem_req, bus.mem_we}); end
        // assert reset between clock edges
        #1;
        reset = 1'b1;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rmid_req_async: got %0b expected 0", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0 || bus.mem_wmask !== 4'b0000) begin errors++; $display("FAIL rmid_we_mask: got %0b/%b expected 0/0000", bus.mem_we, bus.mem_wmask); end
        checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rmid_addr_wdata: got %h/%h expected 0/0", bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.InstrF !== 32'h0 || bus.ReadDataM !== 32'h0) begin errors++; $display("FAIL rmid_rdregs: got %h/%h expected 0/0", bus.InstrF, bus.ReadDataM); end
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.DataWeM   = 1'b0;
        bus.ByteEnM   = 4'b0000;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_6666;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rmid_post_idle: got %0b expected 0", bus.mem_req); end
        tick();
        #1;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h600 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rmid_regrant: got req=%0b addr=%h we=%0b expected 1/00000600/0", bus.mem_req, bus.mem_addr, bus.mem_we); end
        tick();
        bus.mem_ready = 1'b0;
        #1;
        checks++; if (bus.DataValidM !== 1'b1 || bus.ReadDataM !== 32'h6666) begin errors++; $display("FAIL rmid_load: got valid=%0b data=%h expected 1/00006666", bus.DataValidM, bus.ReadDataM); end
        tick();
        clear_inputs();
        #1;
        $display("test_reset_mid done");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_store_wait();
        test_simultaneous();
        test_alternation();
        test_contention_priority();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
